// File: rtl/uart_cmd_decoder_pkg.sv
// Shared text-mode constants and decoder state encoding, also used by the text buffer
// and the character renderer.
package uart_cmd_decoder_pkg;

  localparam int unsigned COLS        = 80;
  localparam int unsigned ROWS        = 30;
  localparam int unsigned ADDR_W      = 12;
  localparam int unsigned TIMEOUT_CYC = 21700;

  typedef enum logic [1:0] {
    S_COL   = 2'd0,
    S_ROW   = 2'd1,
    S_CHAR  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  // row*80 + col built from shifts: row*64 + row*16 + col
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [7:0] col, input logic [7:0] row);
    logic [ADDR_W-1:0] w_row;
    w_row = ADDR_W'(row);
    return (w_row << 6) + (w_row << 4) + ADDR_W'(col);
  endfunction

endpackage

// File: rtl/uart_cmd_decoder_cmd_timeout.sv
// Inter-byte watchdog: a down-counter reloaded on clear, decremented while enabled,
// flagging expiry when it has run out.
module cmd_timeout #(
  parameter int unsigned TIMEOUT_CYC = 21700
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= LOAD_VAL;
    end else if (clr_i) begin
      r_cnt <= LOAD_VAL;
    end else if (en_i && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // A clear in the same cycle means a byte arrived, so it never counts as expiry
  assign expired_o = en_i && !clr_i && (r_cnt == '0);

endmodule

// File: rtl/uart_cmd_decoder.sv
// Assembles {column, row, ASCII} byte triplets from the UART into single writes to the
// 80x30 text buffer, with range checking and framing resync on timeout or frame error.
module uart_cmd_decoder
  import uart_cmd_decoder_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  input  logic              rx_err_i,
  input  logic              wr_ready_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [7:0]        wr_data_o,
  output logic              err_o,
  output logic              ovf_o,
  output logic [1:0]        state_o
);

  // Write handshake: a write transfers on any rising edge where wr_en_o && wr_ready_i;
  // while wr_en_o is high and wr_ready_i is low, wr_addr_o and wr_data_o hold stable,
  // and wr_en_o never drops before the transfer except on reset.

  state_t     r_state;
  logic [7:0] r_col;
  logic [7:0] r_row;

  logic w_tmo_en;
  logic w_tmo_clr;
  logic w_expired;
  logic w_in_range;

  assign w_tmo_en   = (r_state == S_ROW) || (r_state == S_CHAR);
  assign w_tmo_clr  = rx_valid_i || rx_err_i || !w_tmo_en;
  assign w_in_range = (r_col < 8'(COLS)) && (r_row < 8'(ROWS));
  assign state_o    = r_state;

  cmd_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_cmd_timeout (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (w_tmo_clr),
    .en_i      (w_tmo_en),
    .expired_o (w_expired)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_COL;
      r_col     <= '0;
      r_row     <= '0;
      wr_en_o   <= 1'b0;
      wr_addr_o <= '0;
      wr_data_o <= '0;
      err_o     <= 1'b0;
      ovf_o     <= 1'b0;
    end else begin
      err_o <= 1'b0;
      ovf_o <= 1'b0;
      case (r_state)
        S_COL: begin
          if (rx_err_i) begin
            err_o <= 1'b1;
          end else if (rx_valid_i) begin
            r_col   <= rx_data_i;
            r_state <= S_ROW;
          end
        end
        S_ROW: begin
          if (rx_err_i) begin
            err_o   <= 1'b1;
            r_state <= S_COL;
          end else if (rx_valid_i) begin
            r_row   <= rx_data_i;
            r_state <= S_CHAR;
          end else if (w_expired) begin
            err_o   <= 1'b1;
            r_state <= S_COL;
          end
        end
        S_CHAR: begin
          if (rx_err_i) begin
            err_o   <= 1'b1;
            r_state <= S_COL;
          end else if (rx_valid_i) begin
            if (w_in_range) begin
              wr_addr_o <= cell_addr(r_col, r_row);
              wr_data_o <= rx_data_i;
              wr_en_o   <= 1'b1;
              r_state   <= S_WRITE;
            end else begin
              err_o   <= 1'b1;
              r_state <= S_COL;
            end
          end else if (w_expired) begin
            err_o   <= 1'b1;
            r_state <= S_COL;
          end
        end
        S_WRITE: begin
          // Frame errors are ignored here: the command is already complete
          if (rx_valid_i) begin
            ovf_o <= 1'b1;
          end
          if (wr_en_o && wr_ready_i) begin
            wr_en_o <= 1'b0;
            r_state <= S_COL;
          end
        end
        default: r_state <= S_COL;
      endcase
    end
  end

endmodule
